sd_sample_player: RTL and testbench
===================================

SD_SAMPLE_PLAYER -- requirements
Module: sd_sample_player

Interface
REQ-001 SHALL have no parameters; widths below are fixed.
REQ-002 clk  in  1  single system clock; every register is updated on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 note_on  in  1  one-cycle pulse requesting playback of note_code.
REQ-005 note_off  in  1  one-cycle pulse requesting that the current playback stop.
REQ-006 note_code  in  8  sample code, sampled on the note_on pulse.
REQ-007 velocity  in  7  unsigned gain, sampled on the note_on pulse.
REQ-008 sample_tick  in  1  one-cycle audio-rate strobe, at most one per 4 clk cycles.
REQ-009 drv_state  in  3  state of the SD driver; 3'b000 means idle.
REQ-010 drv_start, drv_stop  out  1 each  one-cycle pulses sent to the SD driver.
REQ-011 drv_sample_code  out  8  latched code sent to the SD driver.
REQ-012 fifo_dout  in  16  sample FIFO read data, valid 1 cycle after fifo_rd.
REQ-013 fifo_empty  in  1  sample FIFO is empty.
REQ-014 fifo_rd  out  1  sample FIFO read strobe.
REQ-015 sample_out  out  16  signed, scaled audio sample.
REQ-016 sample_valid  out  1  one-cycle strobe marking a new sample_out value.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 underrun_cnt  out  8  saturating count of underruns.

Function
REQ-019 States SHALL be IDLE, LAUNCH, PRIME, PLAY and STOPPING.
REQ-020 IDLE, with note_on high: latch code and velocity, pulse drv_start, go to LAUNCH.
REQ-021 LAUNCH: wait until drv_state != 0, then go to PRIME.
  - Timeout: if drv_state stays 0 for 64 cycles, go to IDLE with no output.
REQ-022 PRIME: wait until fifo_empty is low and sample_tick arrives, then go to PLAY.
  - That tick issues the first fifo_rd.
REQ-023 PLAY, on each sample_tick with fifo_empty low:
  - fifo_rd pulses in the tick cycle.
  - One cycle later fifo_dout is captured.
  - One cycle after capture, sample_out updates and sample_valid pulses.
  - Total latency from tick to sample_valid is 2 cycles.
REQ-024 Scaling: sample_out = bits [22:7] of the signed product fifo_dout * {1'b0,velocity}.
  - The product is 24-bit.
  - No saturation is needed, since |gain| < 1.
REQ-025 PLAY, on sample_tick with fifo_empty high and drv_state == 0: end of sample, go to IDLE; sample_out is set to 0.
REQ-026 PLAY, on sample_tick with fifo_empty high and drv_state != 0: underrun.
  - Emit sample_out = 0 with sample_valid.
  - Increment underrun_cnt, saturating at 255.
  - Stay in PLAY.
REQ-027 note_off in LAUNCH, PRIME or PLAY: pulse drv_stop and go to STOPPING.
REQ-028 STOPPING: pulse fifo_rd every cycle while fifo_empty is low (flush).
  - Go to IDLE once fifo_empty is high and drv_state == 0.
  - sample_valid stays low in this state.
REQ-029 note_on outside IDLE is a retrigger:
  - Latch the new code and velocity.
  - Pulse drv_stop.
  - Go to STOPPING with retrigger_pend set.
  - On leaving STOPPING with retrigger_pend set, pulse drv_start and go to LAUNCH instead of IDLE.
REQ-030 If note_on and note_off arrive in the same cycle, note_on wins.
REQ-031 fifo_rd SHALL never be asserted while fifo_empty is high.
REQ-032 drv_start and drv_stop SHALL never be high in the same cycle.

Reset
REQ-033 Reset state:
  - State is IDLE.
  - drv_start, drv_stop, fifo_rd, sample_valid and busy are 0.
  - sample_out, drv_sample_code and underrun_cnt are 0.
  - retrigger_pend is cleared.
REQ-034 Reset during playback SHALL abort immediately; drv_stop is not issued, because the driver shares rst.

Structure
REQ-035 The state encodings, DRV_IDLE (3'b000) and the launch-timeout constant (64) SHALL live in a shared package, sd_pkg.
REQ-036 The multiply/shift SHALL be a sub-module, sample_scaler: a registered 1-cycle signed 16x8 multiply producing bits [22:7].

Verification
REQ-037 Normal play:
  - Stimulus: note_on with code 5 and velocity 127; driver model fills the FIFO with 0x4000, 0x8000; driver goes idle.
  - Response: drv_start is pulsed once with drv_sample_code 5.
  - Response: sample_out is 0x3F80 then 0x8100, each exactly 2 cycles after its tick.
  - Response: state returns to IDLE.
REQ-038 Velocity 0: all samples from a non-empty FIFO output 0x0000 with sample_valid.
REQ-039 Underrun:
  - Stimulus: FIFO empty for 3 ticks while drv_state = 3'b010.
  - Response: three zero samples and underrun_cnt = 3.
  - Response: with 260 underruns, the count holds at 255.
REQ-040 note_off mid-play with 10 words in the FIFO:
  - Response: drv_stop pulses.
  - Response: exactly 10 fifo_rd pulses, with no sample_valid.
  - Response: IDLE after drv_state returns to 0.
REQ-041 Retrigger: note_on with code 9 during play yields drv_stop, the flush, then drv_start with drv_sample_code 9.
REQ-042 LAUNCH timeout and reset mid-PLAY:
  - Response: the driver not responding for 64 cycles returns the block to IDLE.
  - Response: rst while in PLAY clears all outputs on the next edge.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================
// Package : sd_pkg
// Brief   : Shared state encodings and constants for sample playback.
// Revision: 1.0
// ============================================================
package sd_pkg;

    localparam int unsigned C_ST_W = 3;

    localparam logic [C_ST_W-1:0] C_ST_IDLE     = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_LAUNCH   = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_PRIME    = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_PLAY     = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_STOPPING = 3'd4;

    localparam logic [2:0] DRV_IDLE = 3'b000;

    // Cycles LAUNCH waits for the driver before giving up.
    localparam int unsigned        C_LAUNCH_TIMEOUT = 64;
    localparam int unsigned        C_TO_W           = 7;
    localparam logic [C_TO_W-1:0]  C_TO_LAST        = C_TO_W'(C_LAUNCH_TIMEOUT - 1);

endpackage
`default_nettype wire

// File: rtl/sample_scaler.sv
`default_nettype none
// ============================================================
// Module  : sample_scaler
// Brief   : Registered signed 16x8 gain multiply, output bits [22:7].
// Revision: 1.0
// ============================================================
module sample_scaler (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic [6:0]  i_gain,
    input  logic        i_valid,
    input  logic        i_zero,
    input  logic        i_clear,
    output logic [15:0] o_sample,
    output logic        o_valid
);

    logic signed [23:0] w_prod;
    logic               w_unused_prod;
    logic [15:0]        r_sample;
    logic               r_valid;

    // Gain is zero-extended so it always acts as a positive fraction below 1.
    assign w_prod        = 24'($signed(i_data)) * 24'($signed({1'b0, i_gain}));
    assign w_unused_prod = ^{w_prod[23], w_prod[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_clear) begin
                r_sample <= '0;
            end else if (i_valid) begin
                r_sample <= i_zero ? 16'h0000 : w_prod[22:7];
            end
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;

endmodule
`default_nettype wire

// File: rtl/sd_sample_player.sv
`default_nettype none
// ============================================================
// Module  : sd_sample_player
// Brief   : Note-triggered SD sample playback with FIFO pacing and gain.
// Revision: 1.0
// ============================================================
module sd_sample_player
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [7:0]  note_code,
    input  logic [6:0]  velocity,
    input  logic        sample_tick,
    input  logic [2:0]  drv_state,
    output logic        drv_start,
    output logic        drv_stop,
    output logic [7:0]  drv_sample_code,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        busy,
    output logic [7:0]  underrun_cnt
);

    logic [C_ST_W-1:0] r_state;
    logic [C_ST_W-1:0] w_state_next;
    logic [7:0]        r_code;
    logic [6:0]        r_vel;
    logic [C_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_underrun_cnt;
    logic              r_pend;
    logic              r_drv_start;
    logic              r_drv_stop;
    logic              r_cap_valid;
    logic              r_cap_zero;

    logic w_drv_busy, w_note, w_to_done, w_scale_valid;
    logic w_drv_start, w_drv_stop, w_fifo_rd, w_cap, w_cap_zero, w_clear;
    logic w_latch, w_underrun, w_pend_set, w_pend_clr;

    assign w_drv_busy = (drv_state != DRV_IDLE);
    assign w_note     = note_on | note_off;
    assign w_to_done  = (r_to_cnt == C_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (note_on) w_state_next = C_ST_LAUNCH;
            end
            C_ST_LAUNCH: begin
                if (w_note)          w_state_next = C_ST_STOPPING;
                else if (w_drv_busy) w_state_next = C_ST_PRIME;
                else if (w_to_done)  w_state_next = C_ST_IDLE;
            end
            C_ST_PRIME: begin
                if (w_note)                           w_state_next = C_ST_STOPPING;
                else if (sample_tick && !fifo_empty)  w_state_next = C_ST_PLAY;
            end
            C_ST_PLAY: begin
                if (w_note) w_state_next = C_ST_STOPPING;
                else if (sample_tick && fifo_empty && !w_drv_busy) w_state_next = C_ST_IDLE;
            end
            C_ST_STOPPING: begin
                if (!note_on && fifo_empty && !w_drv_busy)
                    w_state_next = r_pend ? C_ST_LAUNCH : C_ST_IDLE;
            end
            default: w_state_next = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_drv_start = 1'b0;
        w_drv_stop  = 1'b0;
        w_fifo_rd   = 1'b0;
        w_cap       = 1'b0;
        w_cap_zero  = 1'b0;
        w_clear     = 1'b0;
        w_latch     = 1'b0;
        w_underrun  = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (note_on) begin
                    w_latch     = 1'b1;
                    w_drv_start = 1'b1;
                end
            end
            C_ST_LAUNCH, C_ST_PRIME, C_ST_PLAY: begin
                if (note_on) begin
                    w_latch    = 1'b1;
                    w_drv_stop = 1'b1;
                    w_pend_set = 1'b1;
                end else if (note_off) begin
                    w_drv_stop = 1'b1;
                end else if (sample_tick && (r_state != C_ST_LAUNCH)) begin
                    if (!fifo_empty) begin
                        w_fifo_rd = 1'b1;
                        w_cap     = 1'b1;
                    end else if (r_state == C_ST_PLAY) begin
                        if (w_drv_busy) begin
                            w_cap      = 1'b1;
                            w_cap_zero = 1'b1;
                            w_underrun = 1'b1;
                        end else begin
                            w_clear = 1'b1;
                        end
                    end
                end
            end
            C_ST_STOPPING: begin
                w_fifo_rd = !fifo_empty;
                if (note_on) begin
                    w_latch    = 1'b1;
                    w_drv_stop = 1'b1;
                    w_pend_set = 1'b1;
                end else if (fifo_empty && !w_drv_busy && r_pend) begin
                    w_drv_start = 1'b1;
                    w_pend_clr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code         <= '0;
            r_vel          <= '0;
            r_to_cnt       <= '0;
            r_underrun_cnt <= '0;
            r_pend         <= 1'b0;
            r_drv_start    <= 1'b0;
            r_drv_stop     <= 1'b0;
            r_cap_valid    <= 1'b0;
            r_cap_zero     <= 1'b0;
        end else begin
            r_drv_start <= w_drv_start;
            r_drv_stop  <= w_drv_stop;
            r_cap_valid <= w_cap;
            r_cap_zero  <= w_cap_zero;
            if (w_latch) begin
                r_code <= note_code;
                r_vel  <= velocity;
            end
            if (w_pend_set) begin
                r_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
            end
            if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end
            r_to_cnt <= (r_state == C_ST_LAUNCH) ? r_to_cnt + C_TO_W'(1) : '0;
        end
    end

    // An in-flight sample is dropped if the note is stopped or retriggered.
    assign w_scale_valid = r_cap_valid && (r_state == C_ST_PLAY) && !w_note;

    sample_scaler u_scaler (
        .clk      (clk),
        .rst      (rst),
        .i_data   (fifo_dout),
        .i_gain   (r_vel),
        .i_valid  (w_scale_valid),
        .i_zero   (r_cap_zero),
        .i_clear  (w_clear),
        .o_sample (sample_out),
        .o_valid  (sample_valid)
    );

    assign drv_start       = r_drv_start;
    assign drv_stop        = r_drv_stop;
    assign drv_sample_code = r_code;
    assign fifo_rd         = w_fifo_rd;
    assign busy            = (r_state != C_ST_IDLE);
    assign underrun_cnt    = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sd_sample_player.sv
`default_nettype none
// ============================================================
// Module  : tb_sd_sample_player
// Brief   : Randomized bench with FIFO/driver model and sample scoreboard.
// Revision: 1.0
// ============================================================
module tb_sd_sample_player;

    logic        clk = 1'b0;
    logic        rst, note_on, note_off, sample_tick, fifo_empty;
    logic [7:0]  note_code;
    logic [6:0]  velocity;
    logic [2:0]  drv_state;
    logic [15:0] fifo_dout;
    logic        drv_start, drv_stop, fifo_rd, sample_valid, busy;
    logic [7:0]  drv_sample_code, underrun_cnt;
    logic [15:0] sample_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] fq[$];
    int          exp_cyc_q[$];
    logic [15:0] exp_val_q[$];
    logic [15:0] obs_q[$];

    int n_start, n_stop, n_rd, n_valid, n_busy, n_viol;
    int last_start_cyc, last_stop_cyc, last_rd_cyc;
    logic [7:0] code_at_start;
    bit         model_play = 1'b0;
    logic [6:0] model_vel  = '0;
    int         model_underruns = 0;
    logic       rd_seen;

    always #5 clk = ~clk;

    sd_sample_player dut (
        .clk             (clk),
        .rst             (rst),
        .note_on         (note_on),
        .note_off        (note_off),
        .note_code       (note_code),
        .velocity        (velocity),
        .sample_tick     (sample_tick),
        .drv_state       (drv_state),
        .drv_start       (drv_start),
        .drv_stop        (drv_stop),
        .drv_sample_code (drv_sample_code),
        .fifo_dout       (fifo_dout),
        .fifo_empty      (fifo_empty),
        .fifo_rd         (fifo_rd),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .busy            (busy),
        .underrun_cnt    (underrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    // Observes one cycle and applies the playback rules to the bench FIFO.
    task automatic monitor();
        int p;
        rd_seen = fifo_rd;
        if (fifo_rd && fifo_empty) n_viol++;
        if (drv_start && drv_stop) n_viol++;
        if (busy) n_busy++;
        if (drv_start) begin
            n_start++;
            code_at_start  = drv_sample_code;
            last_start_cyc = cyc;
        end
        if (drv_stop) begin
            n_stop++;
            last_stop_cyc = cyc;
        end
        if (fifo_rd) begin
            n_rd++;
            last_rd_cyc = cyc;
        end
        if (sample_valid) begin
            n_valid++;
            obs_q.push_back(sample_out);
            if (exp_cyc_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("sample_value", sample_out, exp_val_q.pop_front());
                check("sample_latency", cyc, exp_cyc_q.pop_front());
            end
        end
        if (sample_tick && model_play) begin
            if (fq.size() > 0) begin
                p = int'($signed(fq[0])) * int'(model_vel);
                exp_cyc_q.push_back(cyc + 2);
                exp_val_q.push_back(16'(p >>> 7));
            end else if (drv_state != 3'b000) begin
                exp_cyc_q.push_back(cyc + 2);
                exp_val_q.push_back(16'h0000);
                model_underruns++;
            end else begin
                model_play = 1'b0;
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rd_seen && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty  = (fq.size() == 0);
        note_on     = 1'b0;
        note_off    = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic tick(input int gap);
        repeat (gap - 1) step();
        sample_tick = 1'b1;
        step();
    endtask

    task automatic push_word(input logic [15:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_counts();
        n_start = 0; n_stop = 0; n_rd = 0; n_valid = 0; n_busy = 0;
        last_start_cyc = 0; last_stop_cyc = 0; last_rd_cyc = 0;
        obs_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        drv_state  = 3'b000;
        exp_cyc_q.delete();
        exp_val_q.delete();
        model_play = 1'b0;
        model_underruns = 0;
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_busy"},       busy, 0);
        check({tag, "_drv_start"},  drv_start, 0);
        check({tag, "_drv_stop"},   drv_stop, 0);
        check({tag, "_fifo_rd"},    fifo_rd, 0);
        check({tag, "_valid"},      sample_valid, 0);
        check({tag, "_sample_out"}, sample_out, 0);
        check({tag, "_code"},       drv_sample_code, 0);
        check({tag, "_underruns"},  underrun_cnt, 0);
    endtask

    task automatic wait_start(input string tag);
        int s0;
        s0 = n_start;
        for (int i = 0; i < 40 && n_start == s0; i++) step();
        check(tag, n_start - s0, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) step();
        check(tag, busy, 0);
    endtask

    task automatic launch(input logic [7:0] code, input logic [6:0] vel,
                          input bit with_off, input logic [2:0] ack);
        clear_counts();
        note_code = code;
        velocity  = vel;
        note_on   = 1'b1;
        note_off  = with_off;
        step();
        note_code = 8'($urandom);
        velocity  = 7'($urandom);
        wait_start("start_pulse");
        check("start_code", code_at_start, code);
        repeat ($urandom_range(3, 0)) step();
        drv_state = ack;
        model_vel = vel;
    endtask

    task automatic finish_play(input string tag);
        drv_state = 3'b000;
        tick($urandom_range(7, 4));
        repeat (4) step();
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_out"},  sample_out, 0);
        check({tag, "_sb_left"},  exp_cyc_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [6:0] v2;
        int nw;
        rst = 1'b1; note_on = 1'b0; note_off = 1'b0; sample_tick = 1'b0;
        note_code = '0; velocity = '0; drv_state = 3'b000;
        fifo_dout = '0; fifo_empty = 1'b1; n_viol = 0;
        clear_counts();
        @(negedge clk);
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;

        // Normal play with fixed words
        launch(8'd5, 7'd127, 1'b0, 3'b001);
        push_word(16'h4000);
        push_word(16'h8000);
        model_play = 1'b1;
        repeat (2) tick($urandom_range(7, 4));
        finish_play("normal");
        check("normal_starts", n_start, 1);
        check("normal_nvalid", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("normal_s0", obs_q[0], 16'h3F80);
            check("normal_s1", obs_q[1], 16'h8100);
        end

        // Random notes; the first one also carries note_off in the same cycle
        for (int it = 0; it < 3; it++) begin
            launch(8'($urandom), 7'($urandom), (it == 0), 3'($urandom_range(7, 1)));
            nw = $urandom_range(8, 3);
            repeat (nw) push_word(16'($urandom));
            model_play = 1'b1;
            repeat (nw) tick($urandom_range(7, 4));
            finish_play("random");
            check("random_nvalid", n_valid, nw);
            check("random_nostop", n_stop, 0);
        end

        // Velocity zero
        launch(8'($urandom), 7'd0, 1'b0, 3'b001);
        repeat (4) push_word(16'($urandom_range(65535, 1)));
        model_play = 1'b1;
        repeat (4) tick($urandom_range(7, 4));
        finish_play("vel0");
        check("vel0_nvalid", n_valid, 4);

        // Underruns and saturation
        apply_reset();
        launch(8'($urandom), 7'($urandom), 1'b0, 3'b010);
        push_word(16'($urandom));
        model_play = 1'b1;
        repeat (4) tick(4);
        repeat (2) step();
        check("underrun_3", underrun_cnt, 3);
        check("underrun_nvalid", n_valid, 4);
        repeat (257) tick(4);
        repeat (2) step();
        check("underrun_sat", underrun_cnt, (model_underruns > 255) ? 255 : model_underruns);
        check("underrun_sat_const", underrun_cnt, 255);
        finish_play("underrun");

        // note_off mid-play with 10 words pending
        launch(8'($urandom), 7'($urandom), 1'b0, 3'b001);
        repeat (3) push_word(16'($urandom));
        model_play = 1'b1;
        repeat (2) tick($urandom_range(7, 4));
        repeat (3) step();
        repeat (9) push_word(16'($urandom));
        model_play = 1'b0;
        clear_counts();
        note_off = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            sample_tick = (i % 4 == 3);
            step();
        end
        drv_state = 3'b000;
        wait_idle("off_idle");
        check("off_stops", n_stop, 1);
        check("off_reads", n_rd, 10);
        check("off_valids", n_valid, 0);
        check("off_starts", n_start, 0);

        // Retrigger with code 9 during play
        launch(8'd3, 7'($urandom), 1'b0, 3'b001);
        repeat (2) push_word(16'($urandom));
        model_play = 1'b1;
        tick($urandom_range(7, 4));
        repeat (3) step();
        repeat (4) push_word(16'($urandom));
        model_play = 1'b0;
        clear_counts();
        v2 = 7'($urandom_range(127, 1));
        note_code = 8'd9;
        velocity  = v2;
        note_on   = 1'b1;
        step();
        note_code = 8'($urandom);
        velocity  = 7'($urandom);
        repeat (12) step();
        drv_state = 3'b000;
        wait_start("retrig_start");
        check("retrig_code", code_at_start, 9);
        check("retrig_stops", n_stop, 1);
        check("retrig_reads", n_rd, 5);
        check("retrig_order", (last_stop_cyc < last_rd_cyc) && (last_rd_cyc < last_start_cyc), 1);
        check("retrig_valids", n_valid, 0);
        check("retrig_busy", busy, 1);
        drv_state = 3'b001;
        model_vel = v2;
        repeat (2) push_word(16'($urandom));
        model_play = 1'b1;
        repeat (2) tick($urandom_range(7, 4));
        finish_play("retrig");

        // Launch timeout: driver never answers
        clear_counts();
        note_code = 8'($urandom);
        velocity  = 7'($urandom);
        note_on   = 1'b1;
        step();
        n_busy = 0;
        repeat (80) step();
        check("timeout_busy_cycles", n_busy, 64);
        check("timeout_idle", busy, 0);
        check("timeout_stops", n_stop, 0);
        check("timeout_starts", n_start, 1);

        // Reset in the middle of play, with a sample in flight
        apply_reset();
        launch(8'($urandom_range(255, 1)), 7'($urandom_range(127, 1)), 1'b0, 3'b010);
        push_word(16'($urandom_range(65535, 1)));
        model_play = 1'b1;
        repeat (2) tick(4);
        repeat (2) step();
        check("pre_rst_underruns", underrun_cnt, 1);
        push_word(16'($urandom_range(65535, 1)));
        tick(4);
        clear_counts();
        apply_reset();
        check_idle("rst_mid_play");
        repeat (3) step();
        check("rst_no_valid", n_valid, 0);

        check("protocol_violations", n_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
